// File: rtl/ide_sector_ctrl.sv
// Single-sector LBA28 PIO read/write sequencer. Drives an IDE register-cycle
// engine one access at a time and moves 256 words to/from a sector buffer.
module ide_sector_ctrl #(
    parameter int unsigned POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        wr,
    input  logic [27:0] lba,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  buf_addr,
    input  logic [15:0] buf_rd_data,
    output logic [15:0] buf_wr_data,
    output logic        buf_we,
    output logic        ata_rd,
    output logic        ata_wr,
    output logic [4:0]  ata_addr,
    output logic [15:0] ata_in,
    input  logic [15:0] ata_out,
    input  logic        ata_done
);
    localparam int unsigned PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [4:0] A_DATA   = 5'h10;
    localparam logic [4:0] A_SECCNT = 5'h12;
    localparam logic [4:0] A_LBA0   = 5'h13;
    localparam logic [4:0] A_LBA1   = 5'h14;
    localparam logic [4:0] A_LBA2   = 5'h15;
    localparam logic [4:0] A_DRVHD  = 5'h16;
    localparam logic [4:0] A_STATUS = 5'h17;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RDY, S_SETUP, S_WAIT_DRQ, S_XFER, S_WAIT_END, S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic            wr_mode_q, wr_mode_d;
    logic [27:0]     lba_q, lba_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      buf_addr_q, buf_addr_d;
    logic [15:0]     buf_wr_data_q, buf_wr_data_d;
    logic            buf_we_q, buf_we_d;
    logic            ata_rd_q, ata_rd_d;
    logic            ata_wr_q, ata_wr_d;
    logic [4:0]      ata_addr_q, ata_addr_d;
    logic [15:0]     ata_in_q, ata_in_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [2:0]      step_q, step_d;
    logic            gap_q, gap_d;

    logic            acc_active, acc_done, can_issue;
    logic [PW-1:0]   poll_next;
    logic            poll_hit, poll_state, poll_more, fail;
    logic            st_bsy, st_drq, st_err;
    logic [4:0]      setup_addr;
    logic [15:0]     setup_data;

    // gap_q is set once the strobes have been low for a full cycle; issuing only
    // then gives the engine two idle cycles between accesses.
    assign acc_active = ata_rd_q | ata_wr_q;
    assign acc_done   = acc_active & ata_done;
    assign can_issue  = ~acc_active & gap_q;
    assign poll_next  = poll_q + PW'(1);
    assign poll_hit   = (poll_next == POLL_MAX);
    assign st_bsy     = ata_out[7];
    assign st_drq     = ata_out[3];
    assign st_err     = ata_out[0];
    assign poll_state = (state_q == S_WAIT_RDY) || (state_q == S_WAIT_DRQ) ||
                        (state_q == S_WAIT_END);

    always_comb begin
        setup_addr = A_STATUS;
        setup_data = wr_mode_q ? 16'h0030 : 16'h0020;
        case (step_q)
            3'd0: begin setup_addr = A_SECCNT; setup_data = 16'h0001; end
            3'd1: begin setup_addr = A_LBA0;   setup_data = {8'h00, lba_q[7:0]}; end
            3'd2: begin setup_addr = A_LBA1;   setup_data = {8'h00, lba_q[15:8]}; end
            3'd3: begin setup_addr = A_LBA2;   setup_data = {8'h00, lba_q[23:16]}; end
            3'd4: begin setup_addr = A_DRVHD;  setup_data = {8'h00, 4'hE, lba_q[27:24]}; end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wr_mode_d     = wr_mode_q;
        lba_d         = lba_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_wr_data_d = buf_wr_data_q;
        buf_we_d      = 1'b0;
        ata_rd_d      = ata_rd_q;
        ata_wr_d      = ata_wr_q;
        ata_addr_d    = ata_addr_q;
        ata_in_d      = ata_in_q;
        poll_d        = poll_q;
        step_d        = step_q;
        gap_d         = ~acc_active;
        poll_more     = 1'b0;
        fail          = 1'b0;

        if (acc_done) begin
            ata_rd_d = 1'b0;
            ata_wr_d = 1'b0;
        end
        // Read path advances the index after the store strobe has used it.
        if (buf_we_q) buf_addr_d = buf_addr_q + 8'd1;
        if (poll_state && can_issue) begin
            ata_rd_d   = 1'b1;
            ata_addr_d = A_STATUS;
            ata_in_d   = 16'h0000;
        end

        case (state_q)
            S_IDLE: if (start) begin
                wr_mode_d = wr;
                lba_d     = lba;
                busy_d    = 1'b1;
                poll_d    = '0;
                state_d   = S_WAIT_RDY;
            end
            S_WAIT_RDY: if (acc_done) begin
                if (!st_bsy) begin
                    state_d = S_SETUP;
                    step_d  = 3'd0;
                end else poll_more = 1'b1;
            end
            S_SETUP: begin
                if (can_issue) begin
                    ata_wr_d   = 1'b1;
                    ata_addr_d = setup_addr;
                    ata_in_d   = setup_data;
                end
                if (acc_done) begin
                    if (step_q == 3'd5) begin
                        state_d = S_WAIT_DRQ;
                        poll_d  = '0;
                    end else step_d = step_q + 3'd1;
                end
            end
            S_WAIT_DRQ: if (acc_done) begin
                if (!st_bsy && st_err) fail = 1'b1;
                else if (!st_bsy && st_drq) begin
                    state_d    = S_XFER;
                    buf_addr_d = 8'd0;
                end else poll_more = 1'b1;
            end
            S_XFER: begin
                if (can_issue) begin
                    ata_rd_d   = ~wr_mode_q;
                    ata_wr_d   = wr_mode_q;
                    ata_addr_d = A_DATA;
                    ata_in_d   = wr_mode_q ? buf_rd_data : 16'h0000;
                end
                if (acc_done) begin
                    if (!wr_mode_q) begin
                        buf_we_d      = 1'b1;
                        buf_wr_data_d = ata_out;
                        if (buf_addr_q == 8'd255) state_d = S_FINISH;
                    end else if (buf_addr_q == 8'd255) begin
                        state_d = S_WAIT_END;
                        poll_d  = '0;
                    end else buf_addr_d = buf_addr_q + 8'd1;
                end
            end
            S_WAIT_END: if (acc_done) begin
                if (st_bsy) poll_more = 1'b1;
                else if (st_err) fail = 1'b1;
                else state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (poll_more) begin
            if (poll_hit) fail = 1'b1;
            else poll_d = poll_next;
        end
        // Every error is decided on an ata_done, so no access is outstanding.
        if (fail) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_mode_q     <= 1'b0;
            lba_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            buf_addr_q    <= '0;
            buf_wr_data_q <= '0;
            buf_we_q      <= 1'b0;
            ata_rd_q      <= 1'b0;
            ata_wr_q      <= 1'b0;
            ata_addr_q    <= '0;
            ata_in_q      <= '0;
            poll_q        <= '0;
            step_q        <= '0;
            gap_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_mode_q     <= wr_mode_d;
            lba_q         <= lba_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            buf_addr_q    <= buf_addr_d;
            buf_wr_data_q <= buf_wr_data_d;
            buf_we_q      <= buf_we_d;
            ata_rd_q      <= ata_rd_d;
            ata_wr_q      <= ata_wr_d;
            ata_addr_q    <= ata_addr_d;
            ata_in_q      <= ata_in_d;
            poll_q        <= poll_d;
            step_q        <= step_d;
            gap_q         <= gap_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign buf_addr    = buf_addr_q;
    assign buf_wr_data = buf_wr_data_q;
    assign buf_we      = buf_we_q;
    assign ata_rd      = ata_rd_q;
    assign ata_wr      = ata_wr_q;
    assign ata_addr    = ata_addr_q;
    assign ata_in      = ata_in_q;
endmodule

// File: tb/tb_ide_sector_ctrl.sv
// Bench for ide_sector_ctrl: behavioural IDE device/engine model, sector buffer,
// protocol monitor and randomized read/write/error/timeout/reset scenarios.
`timescale 1ns/1ps
module tb_ide_sector_ctrl;
    localparam int unsigned POLL_LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset, start, wr;
    logic [27:0] lba;
    logic        busy, done, err;
    logic [7:0]  buf_addr;
    logic [15:0] buf_rd_data, buf_wr_data;
    logic        buf_we, ata_rd, ata_wr;
    logic [4:0]  ata_addr;
    logic [15:0] ata_in, ata_out;
    logic        ata_done;

    ide_sector_ctrl #(.POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .reset(reset), .start(start), .wr(wr), .lba(lba),
        .busy(busy), .done(done), .err(err),
        .buf_addr(buf_addr), .buf_rd_data(buf_rd_data), .buf_wr_data(buf_wr_data),
        .buf_we(buf_we), .ata_rd(ata_rd), .ata_wr(ata_wr), .ata_addr(ata_addr),
        .ata_in(ata_in), .ata_out(ata_out), .ata_done(ata_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Sector buffer and device model state
    logic [15:0] buf_mem  [256];
    logic [15:0] dev_data [256];
    assign buf_rd_data = buf_mem[buf_addr];

    logic        eng_busy;
    int          lat, low_cnt;
    logic        cap_rd, cap_wr;
    logic [4:0]  cap_addr;
    logic [15:0] cap_in;
    int          rdy_busy_left, end_busy_left;
    logic [7:0]  after_cmd;
    bit          cmd_written;
    int          words, pre_reads, drq_reads, end_reads;
    int          n_done, n_err, n_we;
    logic [4:0]  log_addr[$];
    logic [15:0] log_data[$];
    logic [15:0] rx_words[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_setup(input int rb, input logic [7:0] ac, input int eb);
        rdy_busy_left = rb; after_cmd = ac; end_busy_left = eb;
        cmd_written = 0; words = 0; pre_reads = 0; drq_reads = 0; end_reads = 0;
        n_we = 0;
        log_addr.delete(); log_data.delete(); rx_words.delete();
        for (int i = 0; i < 256; i++) dev_data[i] = 16'($urandom);
    endtask

    // Device model and protocol monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            ata_done = 1'b0; eng_busy = 1'b0; low_cnt = 99; ata_out = 16'h0000;
        end else begin
            n_checks++;
            if (done && err) begin
                n_fail++;
                $display("FAIL done_err_overlap: done=%b err=%b required not both", done, err);
            end
            if (done) n_done++;
            if (err) n_err++;
            if (buf_we) begin
                n_checks++;
                if (n_we >= 256 || buf_addr !== n_we[7:0] || buf_wr_data !== dev_data[n_we[7:0]]) begin
                    n_fail++;
                    $display("FAIL buf_store: addr=%0d data=%h required addr=%0d data=%h",
                             buf_addr, buf_wr_data, n_we, dev_data[n_we[7:0]]);
                end
                buf_mem[buf_addr] = buf_wr_data;
                n_we++;
            end
            if (ata_done) begin
                ata_done = 1'b0;
                n_checks++;
                if (ata_rd || ata_wr) begin
                    n_fail++;
                    $display("FAIL strobe_release: rd=%b wr=%b required 0 after ata_done", ata_rd, ata_wr);
                end
                low_cnt = 1;
            end else if (eng_busy) begin
                n_checks++;
                if (ata_rd !== cap_rd || ata_wr !== cap_wr || ata_addr !== cap_addr || ata_in !== cap_in) begin
                    n_fail++;
                    $display("FAIL access_hold: rd=%b wr=%b addr=%h in=%h required %b %b %h %h",
                             ata_rd, ata_wr, ata_addr, ata_in, cap_rd, cap_wr, cap_addr, cap_in);
                end
                lat--;
                if (lat == 0) begin
                    eng_busy = 1'b0;
                    ata_done = 1'b1;
                    ata_out  = 16'h0000;
                    if (cap_rd && cap_addr == 5'h17) begin
                        if (!cmd_written) begin
                            pre_reads++;
                            if (rdy_busy_left > 0) begin rdy_busy_left--; ata_out = 16'h0080; end
                            else ata_out = 16'h0050;
                        end else if (words == 256) begin
                            end_reads++;
                            if (end_busy_left > 0) begin end_busy_left--; ata_out = 16'h0080; end
                            else ata_out = 16'h0050;
                        end else begin
                            drq_reads++;
                            ata_out = {8'h00, after_cmd};
                        end
                    end else if (cap_rd && cap_addr == 5'h10) begin
                        if (words < 256) ata_out = dev_data[words];
                        words++;
                    end else if (cap_wr && cap_addr == 5'h10) begin
                        rx_words.push_back(cap_in);
                        words++;
                    end else if (cap_wr) begin
                        log_addr.push_back(cap_addr);
                        log_data.push_back(cap_in);
                        if (cap_addr == 5'h17) cmd_written = 1;
                    end
                end
            end else if (ata_rd || ata_wr) begin
                n_checks++;
                if ((ata_rd && ata_wr) || low_cnt < 2) begin
                    n_fail++;
                    $display("FAIL access_start: rd=%b wr=%b low_cycles=%0d required one strobe and >=2",
                             ata_rd, ata_wr, low_cnt);
                end
                cap_rd = ata_rd; cap_wr = ata_wr; cap_addr = ata_addr; cap_in = ata_in;
                eng_busy = 1'b1;
                lat = int'($urandom_range(1, 4));
            end else if (low_cnt < 99) begin
                low_cnt++;
            end
        end
    end

    task automatic do_op(input logic w, input logic [27:0] a, input bit spam, output int outcome);
        int d0, e0;
        d0 = n_done; e0 = n_err; outcome = 0;
        wr = w; lba = a; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: busy=%b required 1", busy);
        end
        for (int i = 0; i < 8000; i++) begin
            if (spam && (i == 20 || i == 21)) begin start = 1'b1; wr = ~w; lba = ~a; end
            else start = 1'b0;
            tick();
            if (n_done != d0 || n_err != e0) begin
                outcome = (n_done != d0) ? 1 : 2;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (outcome == 0) begin
            n_fail++;
            $display("FAIL op_timeout: no done/err within budget, busy=%b", busy);
        end else if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_end: busy=%b required 0", busy);
        end
        repeat (3) tick();
        n_checks++;
        if ((n_done - d0) + (n_err - e0) != 1) begin
            n_fail++;
            $display("FAIL end_pulse: done_cycles=%0d err_cycles=%0d required total 1",
                     n_done - d0, n_err - e0);
        end
    endtask

    task automatic expect_setup_log(input logic w, input logic [27:0] a);
        logic [4:0]  ea [6];
        logic [15:0] ed [6];
        ea[0] = 5'h12; ed[0] = 16'd1;
        ea[1] = 5'h13; ed[1] = 16'(a % 256);
        ea[2] = 5'h14; ed[2] = 16'((a / 256) % 256);
        ea[3] = 5'h15; ed[3] = 16'((a / 65536) % 256);
        ea[4] = 5'h16; ed[4] = 16'(224 + a / 16777216);
        ea[5] = 5'h17; ed[5] = w ? 16'd48 : 16'd32;
        n_checks++;
        if (log_addr.size() != 6) begin
            n_fail++;
            $display("FAIL setup_count: writes=%0d required 6", log_addr.size());
        end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL setup_write%0d: %h=%h required %h=%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic check_read_data();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (buf_mem[i] !== dev_data[i]) bad++;
        n_checks++;
        if (n_we != 256 || bad != 0) begin
            n_fail++;
            $display("FAIL read_data: stores=%0d bad_words=%0d required 256 and 0", n_we, bad);
        end
    endtask

    task automatic check_write_data();
        int bad;
        bad = 0;
        for (int i = 0; i < rx_words.size(); i++) if (rx_words[i] !== (16'(i) ^ 16'hA5A5)) bad++;
        n_checks++;
        if (rx_words.size() != 256 || bad != 0 || n_we != 0) begin
            n_fail++;
            $display("FAIL write_data: words=%0d bad=%0d stores=%0d required 256 0 0", rx_words.size(), bad, n_we);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; wr = 1'b0; lba = '0;
        repeat (3) tick();
        n_checks++;
        if ({busy, done, err, buf_we, ata_rd, ata_wr, ata_addr, ata_in, buf_addr, buf_wr_data} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b rd=%b wr=%b addr=%h in=%h baddr=%h required all 0",
                     busy, ata_rd, ata_wr, ata_addr, ata_in, buf_addr);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({busy, done, err, ata_rd, ata_wr} !== 5'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b err=%b rd=%b wr=%b required 0", busy, done, err, ata_rd, ata_wr);
        end
    endtask

    task automatic test_read_basic();
        int oc;
        model_setup(0, 8'h58, 0);
        for (int i = 0; i < 256; i++) buf_mem[i] = 16'h0000;
        do_op(1'b0, 28'h0123456, 1'b1, oc);
        n_checks++;
        if (oc != 1 || pre_reads != 1) begin
            n_fail++;
            $display("FAIL read_basic: outcome=%0d status_reads=%0d required 1 1", oc, pre_reads);
        end
        expect_setup_log(1'b0, 28'h0123456);
        check_read_data();
    endtask

    task automatic test_write_pattern();
        int oc, eb;
        logic [27:0] a;
        eb = int'($urandom_range(1, 5));
        a = 28'($urandom);
        model_setup(0, 8'h58, eb);
        for (int i = 0; i < 256; i++) buf_mem[i] = 16'(i) ^ 16'hA5A5;
        do_op(1'b1, a, 1'b0, oc);
        n_checks++;
        if (oc != 1 || end_reads != eb + 1) begin
            n_fail++;
            $display("FAIL write_end: outcome=%0d end_reads=%0d required 1 %0d", oc, end_reads, eb + 1);
        end
        expect_setup_log(1'b1, a);
        check_write_data();
    endtask

    task automatic test_wait_rdy();
        int oc;
        logic [27:0] a;
        a = 28'($urandom);
        model_setup(5, 8'h58, 0);
        do_op(1'b0, a, 1'b0, oc);
        n_checks++;
        if (oc != 1 || pre_reads != 6) begin
            n_fail++;
            $display("FAIL wait_rdy: outcome=%0d status_reads=%0d required 1 6", oc, pre_reads);
        end
        expect_setup_log(1'b0, a);
    endtask

    task automatic test_dev_error();
        int oc;
        model_setup(0, 8'h01, 0);
        do_op(1'b0, 28'($urandom), 1'b0, oc);
        n_checks++;
        if (oc != 2 || n_we != 0 || drq_reads != 1) begin
            n_fail++;
            $display("FAIL dev_error: outcome=%0d stores=%0d drq_reads=%0d required 2 0 1", oc, n_we, drq_reads);
        end
    endtask

    task automatic test_timeout();
        int oc;
        model_setup(1000, 8'h58, 0);
        do_op(1'b0, 28'($urandom), 1'b0, oc);
        n_checks++;
        if (oc != 2 || pre_reads != POLL_LIMIT || log_addr.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_rdy: outcome=%0d reads=%0d writes=%0d required 2 %0d 0",
                     oc, pre_reads, log_addr.size(), POLL_LIMIT);
        end
        model_setup(0, 8'h80, 0);
        do_op(1'b1, 28'($urandom), 1'b0, oc);
        n_checks++;
        if (oc != 2 || drq_reads != POLL_LIMIT || rx_words.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_drq: outcome=%0d reads=%0d words=%0d required 2 %0d 0",
                     oc, drq_reads, rx_words.size(), POLL_LIMIT);
        end
    endtask

    task automatic test_back_to_back();
        int oc;
        logic w;
        logic [27:0] a;
        for (int k = 0; k < 4; k++) begin
            w = k[0];
            a = 28'($urandom);
            model_setup(int'($urandom_range(0, 3)), 8'h58, int'($urandom_range(0, 4)));
            for (int i = 0; i < 256; i++) buf_mem[i] = w ? (16'(i) ^ 16'hA5A5) : 16'h0000;
            do_op(w, a, 1'b0, oc);
            n_checks++;
            if (oc != 1) begin
                n_fail++;
                $display("FAIL b2b_op%0d: outcome=%0d required 1", k, oc);
            end
            expect_setup_log(w, a);
            if (w) check_write_data();
            else check_read_data();
        end
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit hit;
        model_setup(0, 8'h58, 0);
        wr = 1'b0; lba = 28'($urandom); start = 1'b1;
        tick();
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 8000; i++) begin
            tick();
            if (n_we >= 100) begin hit = 1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach: stores=%0d required 100", n_we);
        end
        reset = 1'b1;
        tick();
        d0 = n_done; e0 = n_err;
        n_checks++;
        if ({busy, done, err, buf_we, ata_rd, ata_wr, ata_addr, ata_in, buf_addr, buf_wr_data} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b we=%b rd=%b wr=%b addr=%h baddr=%h required all 0",
                     busy, buf_we, ata_rd, ata_wr, ata_addr, buf_addr);
        end
        tick();
        reset = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (n_done != d0 || n_err != e0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: done=%0d err=%0d busy=%b required 0 0 0", n_done - d0, n_err - e0, busy);
        end
    endtask

    initial begin
        n_done = 0; n_err = 0; n_we = 0;
        ata_done = 1'b0; ata_out = 16'h0000; eng_busy = 1'b0; low_cnt = 99;
        for (int i = 0; i < 256; i++) buf_mem[i] = 16'h0000;
        test_reset();
        test_read_basic();
        test_write_pattern();
        test_wait_rdy();
        test_dev_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_read_basic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ide_sector_ctrl.md
IDE_SECTOR_CTRL -- requirements
Module: ide_sector_ctrl

Interface
REQ-001 SHALL have parameter POLL_LIMIT, default 65535: maximum status reads per poll phase before timeout.
REQ-002 SHALL have ports in this order:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- wr  in  1  direction: 1 = buffer to disk, 0 = disk to buffer; sampled with start.
- lba  in  28  LBA28 sector address; sampled with start.
- busy  out  1  high from the cycle after start until done/err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on device error or timeout.
- buf_addr  out  8  word index 0..255 into the sector buffer.
- buf_rd_data  in  16  buffer word at buf_addr; combinational, valid in the same cycle.
- buf_wr_data  out  16  word to store.
- buf_we  out  1  one-cycle store strobe.
- ata_rd  out  1  register read request to the IDE cycle engine.
- ata_wr  out  1  register write request to the IDE cycle engine.
- ata_addr  out  5  {cs[1:0], da[2:0]}.
- ata_in  out  16  write data to the IDE engine.
- ata_out  in  16  read data from the IDE engine; valid while ata_done=1.
- ata_done  in  1  one-cycle completion pulse from the IDE engine.

Function
REQ-003 SHALL use only command-block addresses: data 5'h10, seccount 5'h12, lba0 5'h13, lba1 5'h14, lba2 5'h15, drv/head 5'h16, status/command 5'h17.
REQ-004 SHALL issue each access by asserting exactly one of ata_rd/ata_wr and holding it, ata_addr and ata_in stable until the cycle ata_done=1 is sampled.
REQ-005 SHALL deassert ata_rd/ata_wr in the cycle after ata_done.
REQ-006 SHALL keep ata_rd/ata_wr low for at least 2 cycles before the next access, so the engine returns to idle without a spurious restart.
REQ-007 SHALL capture read data from ata_out in the cycle ata_done=1.
REQ-008 SHALL implement states IDLE, WAIT_RDY, SETUP, WAIT_DRQ, XFER, WAIT_END, FINISH.
REQ-009 IDLE: on start, SHALL latch wr and lba, set busy, clear the poll counter and go to WAIT_RDY.
REQ-010 WAIT_RDY: SHALL read status repeatedly; on BSY(bit7)=0 SHALL go to SETUP.
REQ-011 SETUP: SHALL write, in this order, seccount=16'h0001, lba0=lba[7:0], lba1=lba[15:8], lba2=lba[23:16], drv/head={8'h00,4'hE,lba[27:24]}, command=16'h0020 (wr=0) or 16'h0030 (wr=1); upper byte is 0 on all except data.
REQ-012 WAIT_DRQ: SHALL poll status; BSY=0 and ERR(bit0)=1 -> error; BSY=0 and DRQ(bit3)=1 -> XFER; otherwise poll again.
REQ-013 XFER: SHALL perform 256 data-register accesses with buf_addr = word index 0..255.
REQ-014 XFER, read: on each ata_done SHALL drive buf_wr_data=ata_out and pulse buf_we with buf_addr = current index.
REQ-015 XFER, write: SHALL drive ata_in=buf_rd_data for the current index, held for the whole access.
REQ-016 After word 255: read SHALL go to FINISH; write SHALL go to WAIT_END.
REQ-017 WAIT_END: SHALL poll status until BSY=0; ERR=1 -> error, else FINISH.
REQ-018 FINISH: SHALL pulse done for 1 cycle, clear busy, return to IDLE.
REQ-019 The poll counter SHALL increment per status read in WAIT_RDY/WAIT_DRQ/WAIT_END and clear on each state entry; reaching POLL_LIMIT reads without exit -> error.
REQ-020 Error: SHALL wait for any outstanding access's ata_done, pulse err 1 cycle, clear busy, return to IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 done and err SHALL never assert in the same cycle.
REQ-023 buf_we SHALL be 0 outside XFER-read.

Reset
REQ-024 Reset SHALL force IDLE with busy, done, err, buf_we, ata_rd, ata_wr = 0 and ata_addr, ata_in, buf_addr, buf_wr_data, poll counter = 0.
REQ-025 Reset mid-transfer SHALL abort at once with no done/err pulse; the IDE engine's own reset provides bus recovery.

Verification
REQ-026 Read, lba=28'h0123456, device model ready -> writes 12=0001, 13=0056, 14=0034, 15=0012, 16=00E0, 17=0020; 256 buf_we pulses with addr 0..255 and model data; done 1 cycle.
REQ-027 Write, buffer word i = i^16'hA5A5 -> command 0030; model receives 256 words in order; WAIT_END polls until model BSY clears; done.
REQ-028 Model BSY=1 for 5 status reads, then ready -> exactly 6 status reads in WAIT_RDY, then SETUP proceeds.
REQ-029 Model status 8'h01 after command -> err pulse, no buf_we, busy low; BSY stuck with POLL_LIMIT=8 -> err after 8 reads.
REQ-030 Checker on every access: ata_rd/ata_wr high until ata_done, low for ≥2 cycles between accesses; start during busy ignored; reset at word 100 -> all outputs 0 next cycle, no done.
